// File: rtl/bk_adder_pipe.sv
// bk_adder_pipe: pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle
//   INPUTS     interleaved operands: INPUTS[2i]=a[i], INPUTS[2i+1]=b[i]
//   sub        0: a+b+cin, 1: a+~b+1 (cin ignored)
//   cin        carry-in for add mode
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   OUTS       {carry-out, sum}; in subtract mode carry-out=1 means no borrow
//   ovf        two's-complement overflow of the signed sum
//
// The carry-in is folded into the prefix tree as an extra bit position 0 with
// g=cin_eff, p=0, so the tree spans WIDTH+1 positions and group G of positions
// [i:0] is directly the carry into operand bit i.
//
// Stage 0 captures g/p. The 2*D-1 prefix levels are split into PIPE_STAGES
// segments; segment k sits behind stage register k, and the last segment plus
// the sum XOR drive the outputs combinationally from the last stage register.
module bk_adder_pipe #(
  parameter int WIDTH       = 12,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] INPUTS,
  input  logic               sub,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     OUTS,
  output logic               ovf
);

  localparam int N = WIDTH + 1;
  localparam int D = $clog2(N);
  localparam int L = 2 * D - 1;
  localparam int S = PIPE_STAGES;

  // first prefix level handled by segment j
  function automatic int seg_base(input int j);
    seg_base = (j * L) / S;
  endfunction

  // stage register feeding level lv, or 0 when lv is fed by the previous level
  function automatic int cut_of(input int lv);
    int r;
    r = 0;
    for (int j = 1; j < S; j++) begin
      if (seg_base(j) == lv) r = j;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] a, b, bx;
  logic             cin_eff;

  logic [S-1:0]          v, adv, load;
  logic                  hole;
  logic [S-1:0][N-1:0]   g_q, p_q, g_d, p_d;
  logic [S-1:0][WIDTH-1:0] pr_q, pr_d;

  logic [L-1:0][N-1:0]   gi_g, gi_p, go_g, go_p;
  logic [N-1:0]          c;

  // operand de-interleave
  for (genvar i = 0; i < WIDTH; i++) begin : g_split
    assign a[i] = INPUTS[2*i];
    assign b[i] = INPUTS[2*i+1];
  end

  assign bx      = b ^ {WIDTH{sub}};
  assign cin_eff = sub | cin;

  // A stage moves on when it holds a beat and something downstream has room:
  // an empty later stage or the consumer taking the result.
  always_comb begin
    adv      = '0;
    load     = '0;
    hole     = 1'b0;
    in_ready = 1'b0;
    for (int k = 0; k < S; k++) begin
      hole = out_ready;
      for (int j = k + 1; j < S; j++) begin
        if (!v[j]) hole = 1'b1;
      end
      adv[k] = v[k] & hole;
    end
    in_ready = !v[0] | adv[0];
    load[0]  = in_valid & in_ready;
    for (int k = 1; k < S; k++) begin
      load[k] = adv[k-1];
    end
  end

  // stage register inputs
  assign g_d[0]  = {a & bx, cin_eff};
  assign p_d[0]  = {a ^ bx, 1'b0};
  assign pr_d[0] = a ^ bx;
  for (genvar k = 1; k < S; k++) begin : g_stage_d
    assign g_d[k]  = go_g[seg_base(k)-1];
    assign p_d[k]  = go_p[seg_base(k)-1];
    assign pr_d[k] = pr_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v    <= '0;
      g_q  <= '0;
      p_q  <= '0;
      pr_q <= '0;
    end else begin
      v <= load | (v & ~adv);
      // data only moves with a beat, so bubbles leave the registers quiet
      for (int k = 0; k < S; k++) begin
        if (load[k]) begin
          g_q[k]  <= g_d[k];
          p_q[k]  <= p_d[k];
          pr_q[k] <= pr_d[k];
        end
      end
    end
  end

  // Prefix levels 0..D-1 are the up-sweep (span 2^lv), levels D..2D-2 the
  // down-sweep (span 2^(2D-2-lv)). Positions beyond N simply do not exist,
  // which is a valid truncation because every node only looks downward.
  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int CJ   = cut_of(lv);
    localparam int DL   = (lv < D) ? lv : (2 * D - 2 - lv);
    localparam int SPAN = 1 << DL;

    if (lv == 0) begin : g_src_stage0
      assign gi_g[lv] = g_q[0];
      assign gi_p[lv] = p_q[0];
    end else if (CJ != 0) begin : g_src_cut
      assign gi_g[lv] = g_q[CJ];
      assign gi_p[lv] = p_q[CJ];
    end else begin : g_src_chain
      assign gi_g[lv] = go_g[lv-1];
      assign gi_p[lv] = go_p[lv-1];
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
      if ((lv < D) ? (((i + 1) % (2 * SPAN)) == 0)
                   : ((((i + 1) % (2 * SPAN)) == SPAN) && (i >= 2 * SPAN))) begin : g_node
        assign go_g[lv][i] = gi_g[lv][i] | (gi_p[lv][i] & gi_g[lv][i-SPAN]);
        assign go_p[lv][i] = gi_p[lv][i] & gi_p[lv][i-SPAN];
      end else begin : g_pass
        assign go_g[lv][i] = gi_g[lv][i];
        assign go_p[lv][i] = gi_p[lv][i];
      end
    end
  end

  // c[i] is the carry into operand bit i; c[WIDTH] is the carry-out
  assign c         = go_g[L-1];
  assign OUTS      = {c[WIDTH], pr_q[S-1] ^ c[WIDTH-1:0]};
  assign ovf       = c[WIDTH] ^ c[WIDTH-1];
  assign out_valid = v[S-1];

endmodule

// File: tb/tb_bk_adder_pipe.sv
// tb_bk_adder_pipe: scoreboard bench for bk_adder_pipe (WIDTH=12, PIPE_STAGES=2).
// Stimulus pushes the expected {ovf, OUTS} into a queue at acceptance; a monitor
// pops and compares each beat the DUT hands over.
module tb_bk_adder_pipe;
  localparam int W = 12;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] INPUTS;
  logic           sub;
  logic           cin;
  logic           out_valid;
  logic           out_ready;
  logic [W:0]     OUTS;
  logic           ovf;

  bk_adder_pipe #(.WIDTH(W), .PIPE_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .INPUTS(INPUTS), .sub(sub), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .OUTS(OUTS), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [W+1:0] exp_q[$];
  int checks    = 0;
  int passes    = 0;
  int cyc       = 0;
  int out_count = 0;
  int acc_count = 0;
  logic prod_done;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2*W-1:0] pack_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction

  // reference: plain integer arithmetic, {ovf, carry, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    logic [W-1:0] bx;
    logic [W:0]   r;
    logic         ov;
    bx = s ? ~b : b;
    r  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (s ? 1'b1 : c)};
    ov = (a[W-1] == bx[W-1]) && (r[W-1] != a[W-1]);
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_count++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL spurious_output: got 0x%0h, expected no beat", OUTS);
      end else begin
        check("result", {18'd0, ovf, OUTS}, {18'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic c, input logic [W+1:0] exp);
    int n;
    in_valid = 1'b1;
    INPUTS   = pack_ops(a, b);
    sub      = s;
    cin      = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end else begin
      exp_q.push_back(exp);
      acc_count++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  logic [W:0]   held;
  int           base, oc, t0, n;
  logic [W-1:0] ra, rb;
  logic         rs, rc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; INPUTS = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1; prod_done = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", OUTS, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    // T1 carry ripple and latency
    @(posedge clk); #1;
    send(12'hFFF, 12'h001, 1'b0, 1'b0, {1'b0, 13'h1000});
    for (int k = 0; k < S - 1; k++) begin
      @(negedge clk);
      check("t1_not_early", out_valid, 0);
    end
    @(negedge clk);
    check("t1_on_time", out_valid, 1);
    drain();

    // T2/T3 and further directed vectors, back to back
    send(12'h005, 12'h007, 1'b1, 1'b0, {1'b0, 13'h0FFE});
    send(12'h800, 12'h001, 1'b1, 1'b0, {1'b1, 13'h17FF});
    send(12'h7FF, 12'h000, 1'b0, 1'b1, {1'b1, 13'h0800});
    send(12'h000, 12'h000, 1'b0, 1'b1, {1'b0, 13'h0001});
    send(12'h800, 12'h800, 1'b0, 1'b0, {1'b1, 13'h1000});
    send(12'hABC, 12'h123, 1'b0, 1'b0, {1'b0, 13'h0BDF});
    send(12'h123, 12'h123, 1'b1, 1'b0, {1'b0, 13'h1000});
    send(12'h005, 12'h007, 1'b1, 1'b1, {1'b0, 13'h0FFE});
    send(12'h7FF, 12'h7FF, 1'b0, 1'b1, {1'b1, 13'h0FFF});
    drain();

    // full throughput with out_ready held high
    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      send(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end
    check("throughput_cycles", cyc - t0, 16);
    drain();

    // T4 back-pressure
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = acc_count;
    oc = out_count;
    prod_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send(W'(12'h100 + k), W'(12'h0F0 - k), k[0], 1'b1,
               model(W'(12'h100 + k), W'(12'h0F0 - k), k[0], 1'b1));
        end
        prod_done = 1'b1;
      end
    join_none
    n = 0;
    @(negedge clk);
    while (in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_ready_fall_count", acc_count - base, S);
    held = OUTS;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_in_ready", in_ready, 0);
      check("t4_stall_out_valid", out_valid, 1);
      check("t4_stall_outs_hold", OUTS, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (!prod_done && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t4_producer_done", prod_done, 1);
    drain();
    check("t4_beat_count", out_count - oc, 8);

    // T5 reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(12'h111, 12'h222, 1'b0, 1'b0, {1'b0, 13'h0333});
    send(12'h444, 12'h555, 1'b0, 1'b0, {1'b0, 13'h0999});
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_outs", OUTS, 0);
    check("t5_rst_ovf", ovf, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    oc = out_count;
    repeat (10) @(negedge clk);
    check("t5_no_stale", out_count, oc);
    check("t5_in_ready", in_ready, 1);

    // random valid/ready mix
    prod_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          logic [W-1:0] xa, xb;
          logic xs, xc;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          xa = W'($urandom); xb = W'($urandom); xs = 1'($urandom); xc = 1'($urandom);
          send(xa, xb, xs, xc, model(xa, xb, xs, xc));
        end
        prod_done = 1'b1;
      end
    join_none
    n = 0;
    while (!prod_done && n < 5000) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom);
      n++;
    end
    check("random_producer_done", prod_done, 1);
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
